// File: rtl/axis_bus_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axis_bus_demux                                                 |
// | Function : packet-aware 1-to-NUM_OUT AXI-Stream distributor with a single |
// |            registered output stage and dropped-packet counter            |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_bus_demux #(
  parameter int          NUM_OUT     = 14,
  parameter int          DATA_W      = 32,
  parameter int          KEEP_W      = 4,
  parameter logic [7:0]  CHOOSE_BASE = 8'd128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          bus_sel,
  input  logic                axis_in_tvalid,
  input  logic [DATA_W-1:0]   axis_in_tdata,
  input  logic [KEEP_W-1:0]   axis_in_tkeep,
  input  logic                axis_in_tlast,
  output logic                axis_in_tready,
  output logic [NUM_OUT-1:0]  axis_out_tvalid,
  output logic [DATA_W-1:0]   axis_out_tdata,
  output logic [KEEP_W-1:0]   axis_out_tkeep,
  output logic                axis_out_tlast,
  input  logic [NUM_OUT-1:0]  axis_out_tready,
  output logic                busy,
  output logic [15:0]         drop_cnt
);

  localparam int DEST_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              state_q;
  logic                reg_valid_q;
  logic [DEST_W-1:0]   reg_dest_q;
  logic [DATA_W-1:0]   reg_data_q;
  logic [KEEP_W-1:0]   reg_keep_q;
  logic                reg_last_q;
  logic [15:0]         drop_cnt_q;

  logic [15:0]         drop_cnt_d;
  logic [DEST_W-1:0]   dest_d;
  logic [8:0]          sel_off_w;
  logic                sel_ok_w;
  logic                reg_ready_w;
  logic                in_ready_w;
  logic                accept_w;

  // A borrow in the 9-bit difference means bus_sel is below CHOOSE_BASE.
  always_comb begin
    sel_off_w  = {1'b0, bus_sel} - {1'b0, CHOOSE_BASE};
    sel_ok_w   = !sel_off_w[8] && (sel_off_w < 9'(NUM_OUT));
    dest_d     = sel_off_w[DEST_W-1:0];
    drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
  end

  always_comb begin
    reg_ready_w = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (reg_dest_q == DEST_W'(i)) reg_ready_w = axis_out_tready[i];
    end
  end

  assign in_ready_w = (state_q == ST_DROP) || !reg_valid_q || reg_ready_w;
  assign accept_w   = axis_in_tvalid && in_ready_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      reg_valid_q <= 1'b0;
      reg_dest_q  <= '0;
      reg_data_q  <= '0;
      reg_keep_q  <= '0;
      reg_last_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      // Drained beat clears valid unless a new beat is loaded below.
      if (reg_valid_q && reg_ready_w) reg_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            if (sel_ok_w) begin
              reg_valid_q <= 1'b1;
              reg_dest_q  <= dest_d;
              reg_data_q  <= axis_in_tdata;
              reg_keep_q  <= axis_in_tkeep;
              reg_last_q  <= axis_in_tlast;
              state_q     <= axis_in_tlast ? ST_IDLE : ST_PASS;
            end else begin
              drop_cnt_q  <= drop_cnt_d;
              state_q     <= axis_in_tlast ? ST_IDLE : ST_DROP;
            end
          end
        end
        ST_PASS: begin
          if (accept_w) begin
            reg_valid_q <= 1'b1;
            reg_data_q  <= axis_in_tdata;
            reg_keep_q  <= axis_in_tkeep;
            reg_last_q  <= axis_in_tlast;
            if (axis_in_tlast) state_q <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (accept_w && axis_in_tlast) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_tvalid
      assign axis_out_tvalid[g] = reg_valid_q && (reg_dest_q == DEST_W'(g));
    end
  endgenerate

  assign axis_in_tready = in_ready_w;
  assign axis_out_tdata = reg_data_q;
  assign axis_out_tkeep = reg_keep_q;
  assign axis_out_tlast = reg_last_q;
  assign busy           = (state_q != ST_IDLE);
  assign drop_cnt       = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_bus_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axis_bus_demux                                              |
// | Function : self-checking bench for axis_bus_demux with packet-level model |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axis_bus_demux;

  localparam int NUM_OUT = 14;
  localparam int DATA_W  = 32;
  localparam int KEEP_W  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          bus_sel = '0;
  logic                axis_in_tvalid = 1'b0;
  logic [DATA_W-1:0]   axis_in_tdata = '0;
  logic [KEEP_W-1:0]   axis_in_tkeep = '0;
  logic                axis_in_tlast = 1'b0;
  logic                axis_in_tready;
  logic [NUM_OUT-1:0]  axis_out_tvalid;
  logic [DATA_W-1:0]   axis_out_tdata;
  logic [KEEP_W-1:0]   axis_out_tkeep;
  logic                axis_out_tlast;
  logic [NUM_OUT-1:0]  axis_out_tready = '1;
  logic                busy;
  logic [15:0]         drop_cnt;

  axis_bus_demux #(
    .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .CHOOSE_BASE(8'd128)
  ) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tdata(axis_in_tdata),
    .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_in_tready(axis_in_tready),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tdata(axis_out_tdata),
    .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tready(axis_out_tready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 ch;
    logic [NUM_OUT-1:0] tv;
    logic [DATA_W-1:0]  data;
    logic [KEEP_W-1:0]  keep;
    logic               last;
    int                 cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    acc_q[$];

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  m_open = 1'b0;
  int  m_dest = -1;
  int  m_drops = 0;
  bit  rdy_low_seen, tv_seen, multi_hot;
  bit  rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Packet-level reference: a beat opens a packet iff the previous accepted
  // beat closed one; its route is fixed by the select code on that beat.
  task automatic model_accept();
    beat_t b;
    acc_q.push_back(cyc);
    if (!m_open) begin
      if (int'(bus_sel) >= 128 && int'(bus_sel) < 128 + NUM_OUT) begin
        m_dest = int'(bus_sel) - 128;
      end else begin
        m_dest = -1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (m_dest >= 0) begin
      b.ch = m_dest; b.tv = NUM_OUT'(1) << m_dest; b.data = axis_in_tdata;
      b.keep = axis_in_tkeep; b.last = axis_in_tlast; b.cyc = cyc + 1;
      exp_q.push_back(b);
    end
    m_open = !axis_in_tlast;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_open  = 1'b0;
      m_drops = 0;
    end else begin
      if (axis_in_tready !== 1'b1) rdy_low_seen = 1'b1;
      if (axis_out_tvalid != '0) tv_seen = 1'b1;
      if ($countones(axis_out_tvalid) > 1) multi_hot = 1'b1;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (axis_out_tvalid[i] && axis_out_tready[i])
          obs_q.push_back('{i, axis_out_tvalid, axis_out_tdata, axis_out_tkeep, axis_out_tlast, cyc});
      end
      if (axis_in_tvalid && axis_in_tready) model_accept();
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      for (int i = 0; i < NUM_OUT; i++) axis_out_tready[i] = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); acc_q.delete();
    rdy_low_seen = 1'b0; tv_seen = 1'b0; multi_hot = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    axis_in_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    idle(1);
  endtask

  // Present one beat and hold it until accepted; returns just after the edge.
  task automatic send_beat(input logic [7:0] sel, input logic [DATA_W-1:0] d,
                           input logic [KEEP_W-1:0] k, input logic l);
    int n;
    bus_sel = sel; axis_in_tdata = d; axis_in_tkeep = k; axis_in_tlast = l;
    axis_in_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (axis_in_tready) break;
      n++;
      if (n > 200) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout: tready stayed %b, required 1", axis_in_tready);
        break;
      end
    end
    @(posedge clk);
    #1;
    axis_in_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors += 6;
    if (axis_in_tready !== 1'b1) begin miscompares++; $display("FAIL rst_tready: got %b req 1", axis_in_tready); end
    if (axis_out_tvalid !== '0) begin miscompares++; $display("FAIL rst_tvalid: got %h req 0", axis_out_tvalid); end
    if (axis_out_tdata !== '0) begin miscompares++; $display("FAIL rst_tdata: got %h req 0", axis_out_tdata); end
    if ({axis_out_tkeep, axis_out_tlast} !== '0) begin miscompares++; $display("FAIL rst_keep_last: got %h req 0", {axis_out_tkeep, axis_out_tlast}); end
    if (drop_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_drop_cnt: got %h req 0", drop_cnt); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b req 0", busy); end
    idle(1);
  endtask

  task automatic test_single_pkt();
    clear_obs();
    axis_out_tready = '1;
    for (int i = 0; i < 4; i++) send_beat(8'd131, DATA_W'(i + 1), 4'hF, i == 3);
    idle(3);
    vectors++;
    if (obs_q.size() != 4) begin miscompares++; $display("FAIL pkt_count: got %0d req 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      vectors += 4;
      if (obs_q[i].tv !== 14'h0008) begin miscompares++; $display("FAIL pkt_tvalid[%0d]: got %h req 0008", i, obs_q[i].tv); end
      if (obs_q[i].data !== DATA_W'(i + 1)) begin miscompares++; $display("FAIL pkt_data[%0d]: got %h req %h", i, obs_q[i].data, i + 1); end
      if (obs_q[i].last !== (i == 3)) begin miscompares++; $display("FAIL pkt_last[%0d]: got %b req %b", i, obs_q[i].last, i == 3); end
      if (obs_q[i].cyc != acc_q[0] + 1 + i) begin miscompares++; $display("FAIL pkt_latency[%0d]: got cyc %0d req %0d", i, obs_q[i].cyc, acc_q[0] + 1 + i); end
    end
    vectors++;
    if (drop_cnt !== 16'h0) begin miscompares++; $display("FAIL pkt_drop_cnt: got %h req 0", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [NUM_OUT-1:0] req_tv[3];
    req_tv[0] = 14'h0001; req_tv[1] = 14'h0001; req_tv[2] = 14'h2000;
    clear_obs();
    send_beat(8'd128, 32'hB0, 4'hF, 1'b0);
    send_beat(8'd128, 32'hB1, 4'h3, 1'b1);
    send_beat(8'd141, 32'hB2, 4'h1, 1'b1);
    idle(3);
    vectors += 2;
    if (rdy_low_seen) begin miscompares++; $display("FAIL b2b_tready: got 0 at some cycle req 1"); end
    if (obs_q.size() != 3) begin miscompares++; $display("FAIL b2b_count: got %0d req 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      vectors += 2;
      if (obs_q[i].tv !== req_tv[i]) begin miscompares++; $display("FAIL b2b_tvalid[%0d]: got %h req %h", i, obs_q[i].tv, req_tv[i]); end
      if (obs_q[i].cyc != obs_q[0].cyc + i) begin miscompares++; $display("FAIL b2b_gap[%0d]: got cyc %0d req %0d", i, obs_q[i].cyc, obs_q[0].cyc + i); end
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    axis_out_tready = '1;
    send_beat(8'd133, 32'hA0, 4'hF, 1'b0);
    axis_out_tready[5] = 1'b0;
    bus_sel = 8'd133; axis_in_tdata = 32'hA1; axis_in_tlast = 1'b0; axis_in_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors += 3;
      if (axis_in_tready !== 1'b0) begin miscompares++; $display("FAIL bp_tready: got %b req 0", axis_in_tready); end
      if (axis_out_tvalid !== 14'h0020) begin miscompares++; $display("FAIL bp_tvalid: got %h req 0020", axis_out_tvalid); end
      if (axis_out_tdata !== 32'hA0) begin miscompares++; $display("FAIL bp_hold: got %h req a0", axis_out_tdata); end
      @(posedge clk);
      #1;
    end
    axis_out_tready = 14'h0020;
    send_beat(8'd133, 32'hA1, 4'hF, 1'b0);
    send_beat(8'd7,   32'hA2, 4'hF, 1'b0);
    send_beat(8'd133, 32'hA3, 4'hF, 1'b1);
    idle(3);
    axis_out_tready = '1;
    vectors++;
    if (obs_q.size() != 4) begin miscompares++; $display("FAIL bp_count: got %0d req 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      vectors += 2;
      if (obs_q[i].tv !== 14'h0020) begin miscompares++; $display("FAIL bp_out_tvalid[%0d]: got %h req 0020", i, obs_q[i].tv); end
      if (obs_q[i].data !== 32'hA0 + i) begin miscompares++; $display("FAIL bp_out_data[%0d]: got %h req %h", i, obs_q[i].data, 32'hA0 + i); end
    end
  endtask

  task automatic test_invalid_sel();
    apply_reset();
    send_beat(8'd5, 32'hC0, 4'hF, 1'b0);
    send_beat(8'd130, 32'hC1, 4'hF, 1'b0);
    send_beat(8'd5, 32'hC2, 4'hF, 1'b1);
    send_beat(8'd142, 32'hC3, 4'hF, 1'b1);
    idle(2);
    @(negedge clk);
    vectors += 4;
    if (tv_seen) begin miscompares++; $display("FAIL inv_tvalid: got valid output req none"); end
    if (rdy_low_seen) begin miscompares++; $display("FAIL inv_tready: got 0 at some cycle req 1"); end
    if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL inv_drop_cnt: got %0d req 2", drop_cnt); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL inv_busy: got %b req 0", busy); end
    idle(1);
  endtask

  task automatic test_sel_change();
    clear_obs();
    send_beat(8'd130, 32'hD0, 4'hF, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL selchg_busy: got %b req 1", busy); end
    send_beat(8'd132, 32'hD1, 4'hF, 1'b0);
    send_beat(8'd132, 32'hD2, 4'hF, 1'b1);
    idle(3);
    vectors++;
    if (obs_q.size() != 3) begin miscompares++; $display("FAIL selchg_count: got %0d req 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i].tv !== 14'h0004) begin miscompares++; $display("FAIL selchg_tvalid[%0d]: got %h req 0004", i, obs_q[i].tv); end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    axis_out_tready = '1;
    send_beat(8'd131, 32'hE0, 4'hF, 1'b0);
    send_beat(8'd131, 32'hE1, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    vectors += 4;
    if (axis_out_tvalid !== '0) begin miscompares++; $display("FAIL arst_tvalid: got %h req 0", axis_out_tvalid); end
    if ({axis_out_tdata, axis_out_tkeep, axis_out_tlast} !== '0) begin miscompares++; $display("FAIL arst_data: got %h req 0", axis_out_tdata); end
    if (drop_cnt !== 16'h0) begin miscompares++; $display("FAIL arst_drop_cnt: got %h req 0", drop_cnt); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b req 0", busy); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    idle(1);
    send_beat(8'd129, 32'h5A5A0001, 4'h7, 1'b1);
    idle(3);
    vectors++;
    if (obs_q.size() != 1) begin miscompares++; $display("FAIL arst_count: got %0d req 1", obs_q.size()); end
    else begin
      vectors += 2;
      if (obs_q[0].tv !== 14'h0002) begin miscompares++; $display("FAIL arst_route: got %h req 0002", obs_q[0].tv); end
      if (obs_q[0].data !== 32'h5A5A0001) begin miscompares++; $display("FAIL arst_rdata: got %h req 5a5a0001", obs_q[0].data); end
    end
  endtask

  task automatic test_random();
    int len, r, gap;
    logic [7:0] sel;
    apply_reset();
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 5);
      r = $urandom_range(0, 9);
      if (r < 8)       sel = 8'(128 + $urandom_range(0, NUM_OUT - 1));
      else if (r == 8) sel = 8'($urandom_range(0, 127));
      else             sel = 8'($urandom_range(128 + NUM_OUT, 255));
      for (int b = 0; b < len; b++) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        if (gap > 0) idle(gap);
        send_beat((b == 0) ? sel : 8'($urandom), $urandom, 4'($urandom), b == len - 1);
      end
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    axis_out_tready = '1;
    idle(5);
    vectors += 3;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd_count: got %0d req %0d", obs_q.size(), exp_q.size()); end
    if (drop_cnt !== 16'(m_drops)) begin miscompares++; $display("FAIL rnd_drop_cnt: got %0d req %0d", drop_cnt, m_drops); end
    if (multi_hot) begin miscompares++; $display("FAIL rnd_onehot: got multiple valid bits req one-hot"); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i].tv !== exp_q[i].tv || obs_q[i].data !== exp_q[i].data ||
          obs_q[i].keep !== exp_q[i].keep || obs_q[i].last !== exp_q[i].last ||
          obs_q[i].cyc < exp_q[i].cyc) begin
        miscompares++;
        $display("FAIL rnd_beat[%0d]: got tv=%h d=%h k=%h l=%b c=%0d req tv=%h d=%h k=%h l=%b c>=%0d",
                 i, obs_q[i].tv, obs_q[i].data, obs_q[i].keep, obs_q[i].last, obs_q[i].cyc,
                 exp_q[i].tv, exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    bus_sel = 8'd0; axis_in_tlast = 1'b1; axis_in_tdata = '0;
    axis_in_tvalid = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    axis_in_tvalid = 1'b0;
    idle(2);
    @(negedge clk);
    vectors += 2;
    if (drop_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_drop_cnt: got %h req ffff", drop_cnt); end
    if (drop_cnt !== 16'(m_drops) || acc_q.size() != 65537) begin
      miscompares++;
      $display("FAIL sat_model: got %h after %0d beats req %h after 65537", drop_cnt, acc_q.size(), m_drops);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_back_to_back();
    test_backpressure();
    test_invalid_sel();
    test_sel_change();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
